// File: rtl/branch_ctrl.sv
// Branch/jump front end for the PC: relative and LUT-based absolute jumps, call/return stack,
// run/halt tracking. Optional taken-branch counter enabled by defining BRANCH_COUNT_EN.
module branch_ctrl #(
  parameter int D      = 12,
  parameter int OFFW   = 8,
  parameter int LUTW   = 4,
  parameter int SDEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [D-1:0]    prog_ctr,
  input  logic [2:0]      br_op,
  input  logic            zero_flag,
  input  logic [OFFW-1:0] br_offset,
  input  logic [LUTW-1:0] lut_idx,
  input  logic            lut_we,
  input  logic [LUTW-1:0] lut_waddr,
  input  logic [D-1:0]    lut_wdata,
  output logic            reljump_en,
  output logic            absjump_en,
  output logic [D-1:0]    target,
  output logic            done,
  output logic            stack_err,
  output logic [15:0]     taken_cnt
);
  localparam int NL = 1 << LUTW;
  localparam int PW = $clog2(SDEPTH + 1);
  localparam int SW = $clog2(SDEPTH);

  localparam logic [2:0] OP_BZ   = 3'd1;
  localparam logic [2:0] OP_BNZ  = 3'd2;
  localparam logic [2:0] OP_JMP  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;

  typedef enum logic [1:0] {IDLE, ARMED, RUN, HALTED} state_t;

  state_t        state_q, state_d;
  logic [D-1:0]  lut_q [NL];
  logic [D-1:0]  lut_d [NL];
  logic [D-1:0]  stk_q [SDEPTH];
  logic [D-1:0]  stk_d [SDEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic          err_q, err_d;
  logic          active, full, empty, push, pop;
  logic [SW-1:0] top_idx, push_idx;
  logic [D-1:0]  ofs_ext;

  assign full     = (ptr_q == PW'(SDEPTH));
  assign empty    = (ptr_q == '0);
  assign top_idx  = SW'(ptr_q - 1'b1);
  assign push_idx = SW'(ptr_q);
  assign ofs_ext  = {{(D-OFFW){br_offset[OFFW-1]}}, br_offset};
  // start overrides any op; reset also masks the combinational jump path
  assign active   = (state_q == RUN) && !start && !reset;
  assign done     = (state_q == HALTED);
  assign stack_err = err_q;

  always_comb begin
    state_d = state_q;
    if (start) state_d = ARMED;
    else begin
      case (state_q)
        ARMED:   state_d = RUN;
        RUN:     if (br_op == OP_HALT) state_d = HALTED;
        default: ;
      endcase
    end
  end

  always_comb begin
    reljump_en = 1'b0;
    absjump_en = 1'b0;
    target     = '0;
    push       = 1'b0;
    pop        = 1'b0;
    err_d      = err_q;
    if (active) begin
      case (br_op)
        OP_BZ:   if (zero_flag)  begin reljump_en = 1'b1; target = ofs_ext; end
        OP_BNZ:  if (!zero_flag) begin reljump_en = 1'b1; target = ofs_ext; end
        OP_JMP:  begin absjump_en = 1'b1; target = lut_q[lut_idx]; end
        OP_CALL: if (full) err_d = 1'b1;
                 else begin absjump_en = 1'b1; target = lut_q[lut_idx]; push = 1'b1; end
        OP_RET:  if (empty) err_d = 1'b1;
                 else begin absjump_en = 1'b1; target = stk_q[top_idx]; pop = 1'b1; end
        default: ;
      endcase
    end
    if (state_d == ARMED) err_d = 1'b0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (push)     ptr_d = ptr_q + 1'b1;
    else if (pop) ptr_d = ptr_q - 1'b1;
    stk_d = stk_q;
    if (push) stk_d[push_idx] = prog_ctr + D'(1);
    lut_d = lut_q;
    // table is frozen while running so targets cannot shift under the program
    if (lut_we && state_q != RUN) lut_d[lut_waddr] = lut_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NL; i++) lut_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      lut_q   <= lut_d;
    end
  end

  // stack contents are don't-care until pushed, so they carry no reset
  always_ff @(posedge clk) stk_q <= stk_d;

`ifdef BRANCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ARMED) cnt_d = '0;
    else if ((reljump_en || absjump_en) && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign taken_cnt = cnt_q;
`else
  assign taken_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_ctrl.sv
// Row-driven bench for branch_ctrl: each row drives one cycle and queues the expected outputs.
module tb_branch_ctrl;
  logic        clk, reset, start, zero_flag, lut_we;
  logic [11:0] prog_ctr, lut_wdata, target;
  logic [2:0]  br_op;
  logic [7:0]  br_offset;
  logic [3:0]  lut_idx, lut_waddr;
  logic        reljump_en, absjump_en, done, stack_err;
  logic [15:0] taken_cnt;

  branch_ctrl #(.D(12), .OFFW(8), .LUTW(4), .SDEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_ctr(prog_ctr), .br_op(br_op),
    .zero_flag(zero_flag), .br_offset(br_offset), .lut_idx(lut_idx), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .reljump_en(reljump_en),
    .absjump_en(absjump_en), .target(target), .done(done), .stack_err(stack_err),
    .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic rel, abs; logic [11:0] tgt; logic done, err; logic [15:0] cnt;
  } out_t;

  typedef struct packed {
    logic rst, st; logic [2:0] op; logic z; logic [7:0] off; logic [3:0] idx;
    logic [11:0] pc; logic we; logic [3:0] wa; logic [11:0] wd; out_t exp; logic chk;
  } row_t;

`ifdef BRANCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  out_t        obs;
  out_t        sb[$];
  out_t        e;
  logic [15:0] cnt_m;
  int          n_cmp, n_fail;

  assign obs = {reljump_en, absjump_en, target, done, stack_err, taken_cnt};

  function automatic row_t r(logic st, logic [2:0] op, logic z, logic [7:0] off,
                             logic [3:0] idx, logic [11:0] pc, logic rel, logic abs,
                             logic [11:0] tgt, logic dn, logic er);
    row_t x;
    x = '0;
    x.st = st; x.op = op; x.z = z; x.off = off; x.idx = idx; x.pc = pc;
    x.exp.rel = rel; x.exp.abs = abs; x.exp.tgt = tgt; x.exp.done = dn; x.exp.err = er;
    x.chk = 1'b1;
    return x;
  endfunction

  function automatic row_t rs();
    row_t x;
    x = '0; x.rst = 1'b1;
    return x;
  endfunction

  function automatic row_t rw(logic st, logic [3:0] wa, logic [11:0] wd);
    row_t x;
    x = '0; x.st = st; x.we = 1'b1; x.wa = wa; x.wd = wd; x.chk = 1'b1;
    return x;
  endfunction

  // drive one cycle; the expected count is the model value before this edge
  task automatic apply(input row_t x);
    out_t ex;
    reset = x.rst; start = x.st; br_op = x.op; zero_flag = x.z; br_offset = x.off;
    lut_idx = x.idx; prog_ctr = x.pc; lut_we = x.we; lut_waddr = x.wa; lut_wdata = x.wd;
    ex = x.exp;
    ex.cnt = cnt_m;
    sb.push_back(ex);
    if (x.rst || x.st) cnt_m = '0;
    else if (CNT_EN && (x.exp.rel || x.exp.abs) && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
  endtask

  task automatic test_reset();
    row_t q[$];
    q.push_back(rs()); q.push_back(rs());
    q.push_back(r(0, 3'd1, 1, 8'hFC, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd3, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk); e = sb.pop_front();
      if (q[i].chk) begin
        n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL reset[%0d]: got %h want %h", i, obs, e); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    row_t q[$];
    q.push_back(r(1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(1, 3'd1, 1, 8'hFC, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd1, 1, 8'hFC, 0, 0, 1, 0, 12'hFFC, 0, 0));
    q.push_back(r(0, 3'd1, 0, 8'hFC, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd2, 0, 8'h05, 0, 0, 1, 0, 12'h005, 0, 0));
    q.push_back(r(0, 3'd2, 1, 8'h05, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd1, 1, 8'h80, 0, 0, 1, 0, 12'hF80, 0, 0));
    q.push_back(r(0, 3'd2, 0, 8'h7F, 0, 0, 1, 0, 12'h07F, 0, 0));
    q.push_back(r(0, 3'd3, 0, 8'h00, 0, 0, 0, 1, 12'h000, 0, 0));
    q.push_back(r(0, 3'd7, 1, 8'h11, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(1, 3'd1, 1, 8'h11, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk); e = sb.pop_front();
      if (q[i].chk) begin
        n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL branch[%0d]: got %h want %h", i, obs, e); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_call_ret();
    row_t q[$];
    q.push_back(rw(0, 4'd5, 12'hABC));
    q.push_back(r(1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(rw(1, 4'd3, 12'h120));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd4, 0, 8'h00, 3, 12'h040, 0, 1, 12'h120, 0, 0));
    q.push_back(r(0, 3'd3, 0, 8'h00, 5, 12'h120, 0, 1, 12'h000, 0, 0));
    q.push_back(r(0, 3'd5, 0, 8'h00, 0, 12'h000, 0, 1, 12'h041, 0, 0));
    q.push_back(r(0, 3'd5, 0, 8'h00, 0, 12'h041, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 12'h042, 0, 0, 12'h000, 0, 1));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk); e = sb.pop_front();
      if (q[i].chk) begin
        n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL call_ret[%0d]: got %h want %h", i, obs, e); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stack_bounds();
    row_t q[$];
    q.push_back(r(1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 1));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    for (int k = 0; k < 4; k++)
      q.push_back(r(0, 3'd4, 0, 8'h00, 3, 12'h100 + 12'(k), 0, 1, 12'h120, 0, 0));
    q.push_back(r(0, 3'd4, 0, 8'h00, 3, 12'h104, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd5, 0, 8'h00, 0, 12'h105, 0, 1, 12'h104, 0, 1));
    q.push_back(r(0, 3'd5, 0, 8'h00, 0, 12'h106, 0, 1, 12'h103, 0, 1));
    q.push_back(r(1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 1));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(rs()); q.push_back(rs());
    q.push_back(r(1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd5, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 1));
    q.push_back(r(1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 1));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk); e = sb.pop_front();
      if (q[i].chk) begin
        n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL stack[%0d]: got %h want %h", i, obs, e); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    row_t q[$];
    q.push_back(r(0, 3'd6, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd3, 0, 8'h00, 0, 0, 0, 0, 12'h000, 1, 0));
    q.push_back(r(0, 3'd1, 1, 8'h09, 0, 0, 0, 0, 12'h000, 1, 0));
    q.push_back(r(1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 1, 0));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd2, 0, 8'h03, 0, 0, 1, 0, 12'h003, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk); e = sb.pop_front();
      if (q[i].chk) begin
        n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL halt[%0d]: got %h want %h", i, obs, e); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_count();
    row_t q[$];
    logic [15:0] want;
    q.push_back(r(1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd1, 1, 8'h02, 0, 0, 1, 0, 12'h002, 0, 0));
    q.push_back(r(0, 3'd1, 0, 8'h02, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd2, 0, 8'h04, 0, 0, 1, 0, 12'h004, 0, 0));
    q.push_back(r(0, 3'd2, 1, 8'h04, 0, 0, 0, 0, 12'h000, 0, 0));
    q.push_back(r(0, 3'd3, 0, 8'h00, 0, 0, 0, 1, 12'h000, 0, 0));
    q.push_back(r(0, 3'd0, 0, 8'h00, 0, 0, 0, 0, 12'h000, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk); e = sb.pop_front();
      if (q[i].chk) begin
        n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL count[%0d]: got %h want %h", i, obs, e); end
      end
      @(posedge clk); #1;
    end
    want = CNT_EN ? 16'd3 : 16'd0;
    @(negedge clk);
    n_cmp++;
    if (taken_cnt !== want) begin
      n_fail++; $display("FAIL taken_cnt: got %0d want %0d", taken_cnt, want);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cnt_m = '0;
    reset = 1'b1; start = 1'b0; br_op = '0; zero_flag = 1'b0; br_offset = '0;
    lut_idx = '0; prog_ctr = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_branch();
    test_call_ret();
    test_stack_bounds();
    test_halt();
    test_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Control-flow front end that drives the program counter's jump interface: `reljump_en`, `absjump_en` and `target`.
- Decodes the per-cycle branch op from the decoder, evaluates the zero flag, resolves absolute targets through a writable jump LUT, and keeps a small call/return address stack.
- Tracks run/halt state against the same `start` strobe that freezes the PC, and reports `done`.

Parameters:
- D, 12, PC/target width (matches PC).
- OFFW, 8, signed relative-offset width.
- LUTW, 4, jump LUT index width (2^LUTW entries of D bits).
- SDEPTH, 4, return-stack depth (entries of D bits).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run strobe shared with the PC; high = hold/arm.
- prog_ctr  in  D  current PC value.
- br_op  in  3  0 NOP, 1 BZ (relative, taken if zero_flag), 2 BNZ (relative, taken if !zero_flag), 3 JMP (absolute via LUT), 4 CALL (absolute via LUT, push), 5 RET (pop), 6 HALT, 7 reserved (= NOP).
- zero_flag  in  1  ALU zero flag for the current instruction.
- br_offset  in  OFFW  signed relative offset.
- lut_idx  in  LUTW  LUT index for JMP/CALL.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  LUTW  LUT write address.
- lut_wdata  in  D  LUT write data.
- reljump_en  out  1  to PC: add target.
- absjump_en  out  1  to PC: load target.
- target  out  D  jump amount or address.
- done  out  1  high while HALTED.
- stack_err  out  1  sticky overflow/underflow flag.
- taken_cnt  out  16  taken-branch count (see Optional Feature).

Behaviour:
- FSM states: IDLE, ARMED, RUN, HALTED.
  - Reset puts the FSM in IDLE.
  - IDLE -> ARMED when start=1.
  - ARMED -> RUN on the first cycle start=0.
  - RUN -> HALTED when br_op=6 is sampled.
  - RUN or HALTED -> ARMED when start=1.
  - start=1 always wins over br_op in the same cycle.
- Jump outputs:
  - Combinational from the current-cycle inputs plus registered state; zero added latency, so the PC acts on them at the same rising edge.
  - reljump_en and absjump_en are only asserted in RUN with start=0, and are mutually exclusive.
  - target = 0 whenever neither enable is asserted.
- Per-op behaviour:
  - BZ/BNZ taken: reljump_en=1; target = br_offset sign-extended to D bits. Wrap-around is modulo 2^D in the PC adder.
  - BZ/BNZ not taken: both enables 0.
  - JMP: absjump_en=1, target = lut[lut_idx].
  - CALL, stack not full: absjump_en=1, target = lut[lut_idx]; push (prog_ctr+1) mod 2^D at the edge.
  - CALL, stack full: no jump, no push, stack_err set.
  - RET, stack not empty: absjump_en=1, target = top of stack; pop at the edge.
  - RET, stack empty: no jump, no pop, stack_err set.
  - HALT: both enables 0. done=1 from the next cycle, held until leaving HALTED.
- Stack:
  - Pointer range 0..SDEPTH.
  - full = (ptr == SDEPTH), empty = (ptr == 0).
  - Contents are not cleared on pop.
- LUT:
  - Written at the rising edge when lut_we=1 and state != RUN.
  - Writes in RUN are ignored.
  - Reads are combinational.
  - A read of the same index as a same-cycle write returns the old value.
- Reset (including mid-run):
  - State IDLE, stack pointer 0, all LUT entries 0.
  - reljump_en=0, absjump_en=0, target=0, done=0, stack_err=0, taken_cnt=0.
- stack_err clears on reset or on entry to ARMED.

Optional Feature:
- Macro: BRANCH_COUNT_EN.
- Defined: taken_cnt increments by 1 at each edge where reljump_en or absjump_en is 1. It saturates at 16'hFFFF and clears on reset and on ARMED entry.
- Undefined: no counter logic; taken_cnt is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset, then start=1 for 2 cycles, then 0 with br_op=0 -> state RUN; both enables 0; done=0; target=0.
- RUN, br_op=1, zero_flag=1, br_offset=8'hFC, D=12 -> reljump_en=1, target=12'hFFC. Same with zero_flag=0 -> no enables.
- Write lut[3]=12'h120 during ARMED; in RUN at prog_ctr=12'h040, CALL idx 3 -> absjump_en=1, target=12'h120. Later RET -> absjump_en=1, target=12'h041.
- Five CALLs with SDEPTH=4 -> 5th has no jump and stack_err=1. Reset and then RET on empty -> no jump, stack_err=1. Asserting start clears stack_err.
- RUN, HALT op -> done=1 the next cycle and stays 1. A JMP while HALTED -> no enables. start=1 -> done=0.
- With BRANCH_COUNT_EN defined, 3 taken and 2 not-taken branches -> taken_cnt=3. Undefined -> taken_cnt=0.
